// File: rtl/dsa_ctrl_regs.sv
// rtl/dsa_ctrl_regs.sv - control/status register bank in front of the DSA core
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_addr              word address of the access
//   i_write, i_wdata    write strobe and data
//   i_read              read strobe
//   o_rdata             registered read data, held until the next read
//   o_rdata_valid       one-cycle qualifier for o_rdata
//   o_start             one-cycle run start pulse
//   o_step_trig         one-cycle step trigger pulse
//   o_mode_select       0 = SEQ, 1 = SIMD
//   o_step_mode         step mode enable
//   o_inv_scale         inverse scale, Q8.8
//   o_img_width         image width
//   o_img_height        image height
//   i_busy, i_done      DSA status levels
module dsa_ctrl_regs #(
    parameter logic [31:0] ID_VALUE      = 32'h05A0_0001,
    parameter logic [8:0]  DEF_WIDTH     = 9'd64,
    parameter logic [8:0]  DEF_HEIGHT    = 9'd64,
    parameter logic [15:0] DEF_INV_SCALE = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_addr,
    input  logic        i_write,
    input  logic        i_read,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_start,
    output logic        o_mode_select,
    output logic        o_step_mode,
    output logic        o_step_trig,
    output logic [15:0] o_inv_scale,
    output logic [8:0]  o_img_width,
    output logic [8:0]  o_img_height,
    input  logic        i_busy,
    input  logic        i_done
);

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_CMD    = 4'd1;
    localparam logic [3:0] A_STATUS = 4'd2;
    localparam logic [3:0] A_WIDTH  = 4'd3;
    localparam logic [3:0] A_HEIGHT = 4'd4;
    localparam logic [3:0] A_SCALE  = 4'd5;
    localparam logic [3:0] A_CYCLES = 4'd6;
    localparam logic [3:0] A_RUNS   = 4'd7;
    localparam logic [3:0] A_ID     = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        pending;

    logic        done_q;
    logic        done_sticky;
    logic        err_sticky;
    logic [31:0] cycles;
    logic [15:0] runs;
    logic [31:0] rd_mux;

    // Only the low 16 write-data bits land anywhere.
    logic        unused_wdata;
    assign unused_wdata = &{1'b0, i_wdata[31:16]};

    logic locked;
    logic done_rise;
    logic cfg_wr;
    logic cmd_wr;
    logic cmd_start;
    logic cmd_step;
    logic cmd_clr;
    logic start_ok;
    logic err_set;
    logic step_ok;

    assign locked    = i_busy | pending;
    assign done_rise = i_done & ~done_q;

    assign cfg_wr    = i_write && (i_addr == A_CTRL || i_addr == A_WIDTH ||
                                   i_addr == A_HEIGHT || i_addr == A_SCALE);
    assign cmd_wr    = i_write && (i_addr == A_CMD);
    assign cmd_start = cmd_wr & i_wdata[0];
    // STEP is dropped whenever START shares the same write.
    assign cmd_step  = cmd_wr & i_wdata[1] & ~i_wdata[0];
    assign cmd_clr   = cmd_wr & i_wdata[2];

    assign start_ok  = cmd_start & ~locked & (o_img_width != 9'd0) & (o_img_height != 9'd0);
    assign err_set   = (cfg_wr & locked) | (cmd_start & ~start_ok);
    assign step_ok   = cmd_step & o_step_mode & locked;

    // Launch tracking: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Launch tracking: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                // A core that finishes without ever showing busy still ends the launch.
                if (i_busy)         state_next = ST_RUN;
                else if (done_rise) state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (!i_busy) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Launch tracking: outputs
    always_comb begin
        pending = 1'b0;
        if (state == ST_LAUNCH) pending = 1'b1;
    end

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mode_select <= 1'b0;
            o_step_mode   <= 1'b0;
            o_img_width   <= DEF_WIDTH;
            o_img_height  <= DEF_HEIGHT;
            o_inv_scale   <= DEF_INV_SCALE;
        end else if (i_write && !locked) begin
            case (i_addr)
                A_CTRL: begin
                    o_mode_select <= i_wdata[0];
                    o_step_mode   <= i_wdata[1];
                end
                A_WIDTH:  o_img_width  <= i_wdata[8:0];
                A_HEIGHT: o_img_height <= i_wdata[8:0];
                A_SCALE:  o_inv_scale  <= i_wdata[15:0];
                default: ;
            endcase
        end
    end

    // Command pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_start     <= 1'b0;
            o_step_trig <= 1'b0;
        end else begin
            o_start     <= start_ok;
            o_step_trig <= step_ok;
        end
    end

    // Status flags and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            done_sticky <= 1'b0;
            err_sticky  <= 1'b0;
            cycles      <= 32'd0;
            runs        <= 16'd0;
        end else begin
            done_q <= i_done;

            // Set terms come last so they win over a same-cycle clear.
            if (cmd_clr) begin
                done_sticky <= 1'b0;
                err_sticky  <= 1'b0;
            end
            if (done_rise) done_sticky <= 1'b1;
            if (err_set)   err_sticky  <= 1'b1;

            if (start_ok) begin
                cycles <= 32'd0;
            end else if (i_busy && cycles != 32'hFFFF_FFFF) begin
                cycles <= cycles + 32'd1;
            end

            if (done_rise && runs != 16'hFFFF) begin
                runs <= runs + 16'd1;
            end
        end
    end

    // Read mux sees pre-write register values, so read-during-write returns old data.
    always_comb begin
        rd_mux = 32'd0;
        case (i_addr)
            A_CTRL:   rd_mux = {30'd0, o_step_mode, o_mode_select};
            A_STATUS: rd_mux = {28'd0, pending, err_sticky, done_sticky, i_busy};
            A_WIDTH:  rd_mux = {23'd0, o_img_width};
            A_HEIGHT: rd_mux = {23'd0, o_img_height};
            A_SCALE:  rd_mux = {16'd0, o_inv_scale};
            A_CYCLES: rd_mux = cycles;
            A_RUNS:   rd_mux = {16'd0, runs};
            A_ID:     rd_mux = ID_VALUE;
            default:  rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata       <= 32'd0;
            o_rdata_valid <= 1'b0;
        end else begin
            o_rdata_valid <= i_read;
            if (i_read) o_rdata <= rd_mux;
        end
    end

endmodule
